// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between MEM-stage requester and data memory
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency single-outstanding data memory slave
module data_mem_responder #(
   parameter int ADDR_BITS = 14,
   parameter int LATENCY   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int         DEPTH    = 2 ** ADDR_BITS;
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [3:0]             r_cnt;
   logic                   r_write;
   logic [ADDR_BITS-1:0]   r_idx;
   logic [31:0]            r_wdata;
   logic [31:0]            r_rdata;
   logic [31:0]            r_mem [DEPTH];

   logic                   w_accept;
   logic                   w_enter_resp;
   logic                   w_acc_write;
   logic [ADDR_BITS-1:0]   w_acc_idx;
   logic [31:0]            w_acc_wdata;
   logic                   w_unused_addr_bits;

   // Byte-lane and wrap-around address bits are deliberately dropped.
   assign w_unused_addr_bits = ^{bus.req_addr[31:ADDR_BITS+2], bus.req_addr[1:0]};

   assign w_accept     = (r_state == ST_IDLE) && bus.req_valid;
   assign w_enter_resp = (r_state != ST_RESP) && (w_next_state == ST_RESP);

   // With LATENCY==1 the array is accessed on the accept edge itself, before
   // the capture registers hold the request, so use the live inputs then.
   assign w_acc_write = (r_state == ST_IDLE) ? bus.req_write                 : r_write;
   assign w_acc_idx   = (r_state == ST_IDLE) ? bus.req_addr[ADDR_BITS+1:2]   : r_idx;
   assign w_acc_wdata = (r_state == ST_IDLE) ? bus.req_wdata                 : r_wdata;

   assign bus.req_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.resp_rdata = r_rdata;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold until handshake in RESP.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (bus.req_valid) w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (r_cnt == 4'd0) w_next_state = ST_RESP;
         ST_RESP: if (bus.resp_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Latency counter: loaded on accept, decremented while waiting.
   always_ff @(posedge clk) begin
      if (!reset)                                  r_cnt <= 4'd0;
      else if (w_accept)                           r_cnt <= CNT_INIT;
      else if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
   end

   // Capture the request on the accept edge; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_write <= bus.req_write;
         r_idx   <= bus.req_addr[ADDR_BITS+1:2];
         r_wdata <= bus.req_wdata;
      end
   end

   // Memory array: cleared on reset, written only when a store enters RESP.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_enter_resp && w_acc_write) begin
         r_mem[w_acc_idx] <= w_acc_wdata;
      end
   end

   // Response data: store echoes its data, load reads the array; held otherwise.
   always_ff @(posedge clk) begin
      if (!reset)            r_rdata <= '0;
      else if (w_enter_resp) r_rdata <= w_acc_write ? w_acc_wdata : r_mem[w_acc_idx];
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   localparam int LAT_A = 4;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.ADDR_BITS(14), .LATENCY(LAT_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transaction on instance A with optional back-pressure cycles in RESP.
   task automatic run_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input int hold, input string name);
      bus_a.req_valid = 1'b1;
      bus_a.req_write = wr;
      bus_a.req_addr  = addr;
      bus_a.req_wdata = wdata;
      checks++;
      if (bus_a.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_accept: got %0b want 1", name, bus_a.req_ready);
      end
      step();
      bus_a.req_valid = 1'b0;
      bus_a.req_write = ~wr;
      bus_a.req_addr  = ~addr;
      bus_a.req_wdata = ~wdata;
      checks++;
      if ({bus_a.req_ready, bus_a.busy} !== 2'b01) begin
         errors++;
         $display("FAIL %s after_accept {ready,busy}: got %b want 01", name, {bus_a.req_ready, bus_a.busy});
      end
      for (int k = 0; k < LAT_A - 1; k++) begin
         checks++;
         if (bus_a.resp_valid !== 1'b0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_cycle%0d {valid,busy}: got %b want 01", name, k, {bus_a.resp_valid, bus_a.busy});
         end
         step();
      end
      checks++;
      if ({bus_a.resp_valid, bus_a.busy, bus_a.req_ready} !== 3'b110 || bus_a.resp_rdata !== exp) begin
         errors++;
         $display("FAIL %s response: valid/busy/ready=%b rdata=%h want 110 %h", name,
                  {bus_a.resp_valid, bus_a.busy, bus_a.req_ready}, bus_a.resp_rdata, exp);
      end
      for (int h = 0; h < hold; h++) begin
         if (h == 2) begin
            bus_a.req_valid = 1'b1;
            bus_a.req_write = 1'b1;
            bus_a.req_addr  = 32'h0000_0100;
            bus_a.req_wdata = 32'h5555_5555;
         end
         step();
         bus_a.req_valid = 1'b0;
         checks++;
         if ({bus_a.resp_valid, bus_a.req_ready} !== 2'b10 || bus_a.resp_rdata !== exp) begin
            errors++;
            $display("FAIL %s hold%0d: valid/ready=%b rdata=%h want 10 %h", name, h,
                     {bus_a.resp_valid, bus_a.req_ready}, bus_a.resp_rdata, exp);
         end
      end
      bus_a.resp_ready = 1'b1;
      step();
      bus_a.resp_ready = 1'b0;
      checks++;
      if ({bus_a.resp_valid, bus_a.busy, bus_a.req_ready} !== 3'b001 || bus_a.resp_rdata !== exp) begin
         errors++;
         $display("FAIL %s after_handshake: valid/busy/ready=%b rdata=%h want 001 %h", name,
                  {bus_a.resp_valid, bus_a.busy, bus_a.req_ready}, bus_a.resp_rdata, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      checks++;
      if ({bus_a.req_ready, bus_a.resp_valid, bus_a.busy} !== 3'b100 || bus_a.resp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_a: ready/valid/busy=%b rdata=%h want 100 0",
                  {bus_a.req_ready, bus_a.resp_valid, bus_a.busy}, bus_a.resp_rdata);
      end
      checks++;
      if ({bus_b.req_ready, bus_b.resp_valid, bus_b.busy} !== 3'b100 || bus_b.resp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_b: ready/valid/busy=%b rdata=%h want 100 0",
                  {bus_b.req_ready, bus_b.resp_valid, bus_b.busy}, bus_b.resp_rdata);
      end
   endtask

   task automatic test_load_basic();
      run_a(1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, "load_0x40");
   endtask

   task automatic test_store_load();
      run_a(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, "store_0x100");
      run_a(1'b0, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF, 0, "load_0x102");
   endtask

   task automatic test_wrap();
      run_a(1'b1, 32'h0001_0004, 32'h1234_5678, 32'h1234_5678, 0, "store_wrap");
      run_a(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 0, "load_wrap");
   endtask

   task automatic test_backpressure();
      run_a(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5, "hold_load");
      run_a(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, "no_store_during_hold");
   endtask

   task automatic test_reset_drop();
      bus_a.req_valid = 1'b1;
      bus_a.req_write = 1'b1;
      bus_a.req_addr  = 32'h0000_0020;
      bus_a.req_wdata = 32'hAAAA_AAAA;
      step();
      bus_a.req_valid = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++;
      if ({bus_a.req_ready, bus_a.resp_valid, bus_a.busy} !== 3'b100 || bus_a.resp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_store: ready/valid/busy=%b rdata=%h want 100 0",
                  {bus_a.req_ready, bus_a.resp_valid, bus_a.busy}, bus_a.resp_rdata);
      end
      run_a(1'b0, 32'h0000_0020, 32'h0, 32'h0, 0, "load_after_drop");
      run_a(1'b0, 32'h0000_0004, 32'h0, 32'h0, 0, "array_cleared");
   endtask

   task automatic test_latency1();
      bus_b.resp_ready = 1'b1;
      bus_b.req_valid  = 1'b1;
      bus_b.req_write  = 1'b1;
      bus_b.req_addr   = 32'h0000_0008;
      bus_b.req_wdata  = 32'hCAFE_F00D;
      step();
      checks++;
      if ({bus_b.resp_valid, bus_b.req_ready, bus_b.busy} !== 3'b101 || bus_b.resp_rdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lat1_store_resp: valid/ready/busy=%b rdata=%h want 101 cafef00d",
                  {bus_b.resp_valid, bus_b.req_ready, bus_b.busy}, bus_b.resp_rdata);
      end
      bus_b.req_write = 1'b0;
      bus_b.req_wdata = 32'h0;
      step();
      checks++;
      if ({bus_b.resp_valid, bus_b.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL lat1_handshake_gap: valid/ready=%b want 01", {bus_b.resp_valid, bus_b.req_ready});
      end
      step();
      bus_b.req_valid = 1'b0;
      checks++;
      if ({bus_b.resp_valid, bus_b.req_ready} !== 2'b10 || bus_b.resp_rdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lat1_load_resp: valid/ready=%b rdata=%h want 10 cafef00d",
                  {bus_b.resp_valid, bus_b.req_ready}, bus_b.resp_rdata);
      end
      step();
      checks++;
      if ({bus_b.resp_valid, bus_b.req_ready, bus_b.busy} !== 3'b010) begin
         errors++;
         $display("FAIL lat1_idle: valid/ready/busy=%b want 010",
                  {bus_b.resp_valid, bus_b.req_ready, bus_b.busy});
      end
      bus_b.resp_ready = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
      bus_a.req_wdata = '0;   bus_a.resp_ready = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
      bus_b.req_wdata = '0;   bus_b.resp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_load_basic();
      test_store_load();
      test_wrap();
      test_backpressure();
      test_reset_drop();
      test_latency1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
